// File: rtl/imem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_pkg: shared constants, FSM encodings and partition base helper. Rev 1.0
// ----------------------------------------------------------------------------
package imem_pkg;

  localparam int unsigned PART_SIZE = 100;
  localparam int unsigned NUM_PROC  = 10;
  localparam int unsigned SO_BASE   = 1024;

  localparam int unsigned STATE_W = 2;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Address 0 is reserved, so partition pid starts one word past its slot.
  function automatic int unsigned part_base(input logic [3:0] pid, input int unsigned part_size);
    return 32'd1 + part_size * (32'(pid) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/imem_load_fsm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_load_fsm: partition load sequencer with bounds check and done/err pulses. Rev 1.0
// ----------------------------------------------------------------------------
module imem_load_fsm #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned PART_SIZE  = 100,
  parameter int unsigned NUM_PROC   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [3:0]            load_pid,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic                  ld_xfer,
  output logic                  in_load,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err
);
  import imem_pkg::*;

  logic [STATE_W-1:0]    state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic                  err_q, err_d;
  logic                  req_bad;

  assign req_bad = (load_pid == 4'd0) || (32'(load_pid) > NUM_PROC) ||
                   (load_len == '0)   || (32'(load_len) > PART_SIZE);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    offset_d = offset_q;
    err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (req_bad) begin
            err_d = 1'b1;
          end else begin
            base_d   = ADDR_WIDTH'(part_base(load_pid, PART_SIZE));
            len_d    = load_len;
            offset_d = '0;
            state_d  = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (ld_xfer) begin
          offset_d = offset_q + ADDR_WIDTH'(1);
          if (offset_q == len_q - ADDR_WIDTH'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      offset_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      len_q    <= len_d;
      offset_q <= offset_d;
      err_q    <= err_d;
    end
  end

  // offset never exceeds len-1 and len <= PART_SIZE, so writes stay in the partition.
  assign wr_addr   = base_q + offset_q;
  assign in_load   = (state_q == ST_LOAD);
  assign load_busy = in_load;
  assign load_done = (state_q == ST_DONE);
  assign load_err  = err_q;

endmodule
`default_nettype wire

// File: rtl/imem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_port_arbiter: instruction RAM port shared by CPU fetch and UART loader. Rev 1.0
// ----------------------------------------------------------------------------
module imem_port_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned PART_SIZE  = 100,
  parameter int unsigned NUM_PROC   = 10,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_stall,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  input  logic                  load_start,
  input  logic [3:0]            load_pid,
  input  logic [ADDR_WIDTH-1:0] load_len,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);

  logic                  in_load;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic                  ld_gnt;
  logic                  fetch_gnt;
  logic                  ld_xfer;
  logic [STARVE_W-1:0]   starve_q, starve_d;
  logic                  fetch_valid_q, fetch_valid_d;

  imem_load_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PART_SIZE  (PART_SIZE),
    .NUM_PROC   (NUM_PROC)
  ) u_load_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_pid   (load_pid),
    .load_len   (load_len),
    .ld_xfer    (ld_xfer),
    .in_load    (in_load),
    .wr_addr    (ld_addr),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  // Fetch wins by default; the loader only steals a slot after STARVE_MAX denied offers.
  always_comb begin
    ld_gnt   = 1'b0;
    starve_d = starve_q;
    if (!in_load) begin
      starve_d = '0;
    end else if (!fetch_req) begin
      ld_gnt   = 1'b1;
      starve_d = '0;
    end else if (32'(starve_q) >= STARVE_MAX) begin
      if (ld_valid) begin
        ld_gnt   = 1'b1;
        starve_d = '0;
      end
    end else if (ld_valid) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  assign fetch_gnt     = fetch_req & ~ld_gnt;
  assign ld_xfer       = ld_gnt & ld_valid;
  assign fetch_valid_d = fetch_gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q      <= '0;
      fetch_valid_q <= 1'b0;
    end else begin
      starve_q      <= starve_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  assign ld_ready    = ld_gnt;
  assign fetch_stall = fetch_req & ~fetch_gnt;
  assign fetch_valid = fetch_valid_q;
  assign fetch_data  = mem_q;
  assign mem_addr    = ld_gnt ? ld_addr : fetch_addr;
  assign mem_we      = ld_xfer;
  assign mem_wdata   = ld_xfer ? ld_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_imem_port_arbiter: directed bench with a behavioural 4096x32 RAM. Rev 1.0
// ----------------------------------------------------------------------------
module tb_imem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_stall;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          load_start;
  logic [3:0]    load_pid;
  logic [AW-1:0] load_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          load_busy;
  logic          load_done;
  logic          load_err;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;

  logic [DW-1:0] ram [0:4095];
  logic [3:0]    bad_pid [4] = '{4'd0, 4'd11, 4'd2, 4'd2};
  logic [AW-1:0] bad_len [4] = '{12'd5, 12'd5, 12'd101, 12'd0};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_q <= ram[mem_addr];
  end

  imem_port_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .load_start  (load_start),
    .load_pid    (load_pid),
    .load_len    (load_len),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_err    (load_err),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_q       (mem_q)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 32'hC0DE_0000 + 32'(i);
    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_pid = '0; load_len = '0; ld_valid = 1'b0; ld_data = '0;
    repeat (2) @(posedge clk);
    sample;
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_stall", fetch_stall, 0);
    check("rst_ld_ready",    ld_ready,    0);
    check("rst_busy",        load_busy,   0);
    check("rst_done",        load_done,   0);
    check("rst_err",         load_err,    0);
    check("rst_we",          mem_we,      0);
    next_cycle; rst_n = 1'b1;

    // Fetch only from the SO area
    next_cycle; fetch_req = 1'b1; fetch_addr = 12'd1024; sample;
    check("f0_stall", fetch_stall, 0);
    check("f0_valid", fetch_valid, 0);
    check("f0_addr",  mem_addr, 1024);
    next_cycle; fetch_addr = 12'd1025; sample;
    check("f1_valid", fetch_valid, 1);
    check("f1_data",  fetch_data, 32'hC0DE_0400);
    check("f1_stall", fetch_stall, 0);
    next_cycle; fetch_addr = 12'd1026; sample;
    check("f2_valid", fetch_valid, 1);
    check("f2_data",  fetch_data, 32'hC0DE_0401);
    next_cycle; fetch_req = 1'b0; sample;
    check("f3_valid", fetch_valid, 1);
    check("f3_data",  fetch_data, 32'hC0DE_0402);
    next_cycle; sample;
    check("f4_valid", fetch_valid, 0);

    // Load pid 3, len 5, no fetch competition
    next_cycle; load_start = 1'b1; load_pid = 4'd3; load_len = 12'd5; sample;
    check("l3_start_busy", load_busy, 0);
    for (int k = 0; k < 5; k++) begin
      next_cycle; load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h3000_0000 + 32'(k); sample;
      check("l3_ready", ld_ready, 1);
      check("l3_we",    mem_we, 1);
      check("l3_addr",  mem_addr, 32'(201 + k));
      check("l3_wdata", mem_wdata, 32'h3000_0000 + 32'(k));
      check("l3_busy",  load_busy, 1);
      check("l3_done_early", load_done, 0);
    end
    next_cycle; ld_valid = 1'b0; sample;
    check("l3_done", load_done, 1);
    check("l3_done_busy", load_busy, 0);
    check("l3_done_we", mem_we, 0);
    next_cycle; sample;
    check("l3_done_pulse", load_done, 0);
    for (int k = 0; k < 5; k++) check("l3_ram", ram[201 + k], 32'h3000_0000 + 32'(k));
    check("l3_ram_below", ram[200], 32'hC0DE_00C8);
    check("l3_ram_above", ram[206], 32'hC0DE_00CE);
    next_cycle; fetch_req = 1'b1; fetch_addr = 12'd203;
    next_cycle; fetch_req = 1'b0; sample;
    check("l3_rb_valid", fetch_valid, 1);
    check("l3_rb_data",  fetch_data, 32'h3000_0002);

    // Starvation: fetch and loader both requesting continuously
    next_cycle; fetch_req = 1'b1; fetch_addr = 12'd1030; ld_valid = 1'b1; ld_data = 32'h1000_0000;
    load_start = 1'b1; load_pid = 4'd1; load_len = 12'd3; sample;
    check("st_start_ready", ld_ready, 0);
    check("st_start_stall", fetch_stall, 0);
    for (int c = 1; c <= 15; c++) begin
      logic g;
      g = (c % 5 == 0);
      next_cycle; load_start = 1'b0; ld_data = 32'h1000_0000 + 32'(c); sample;
      check("st_stall", fetch_stall, 32'(g));
      check("st_ready", ld_ready, 32'(g));
      check("st_we",    mem_we, 32'(g));
      check("st_done_early", load_done, 0);
      if (g) check("st_addr", mem_addr, 32'(c / 5));
    end
    next_cycle; ld_valid = 1'b0; fetch_req = 1'b0; sample;
    check("st_done", load_done, 1);
    check("st_ram1", ram[1], 32'h1000_0005);
    check("st_ram2", ram[2], 32'h1000_000A);
    check("st_ram3", ram[3], 32'h1000_000F);

    // Illegal requests
    for (int i = 0; i < 4; i++) begin
      next_cycle; fetch_req = 1'b0; ld_valid = 1'b1; ld_data = 32'hDEAD_0000;
      load_start = 1'b1; load_pid = bad_pid[i]; load_len = bad_len[i]; sample;
      check("bad_err_early", load_err, 0);
      check("bad_we0", mem_we, 0);
      next_cycle; load_start = 1'b0; sample;
      check("bad_err", load_err, 1);
      check("bad_busy", load_busy, 0);
      check("bad_ready", ld_ready, 0);
      check("bad_we1", mem_we, 0);
      next_cycle; sample;
      check("bad_err_pulse", load_err, 0);
    end
    ld_valid = 1'b0;

    // Reset in the middle of a load
    next_cycle; load_start = 1'b1; load_pid = 4'd10; load_len = 12'd50; sample;
    for (int k = 0; k < 20; k++) begin
      next_cycle; load_start = 1'b0; ld_valid = 1'b1; ld_data = 32'h5000_0000 + 32'(k); sample;
      check("rl_addr", mem_addr, 32'(901 + k));
      check("rl_we", mem_we, 1);
    end
    next_cycle; rst_n = 1'b0; ld_valid = 1'b0; fetch_addr = '0; sample;
    next_cycle; sample;
    check("rl_busy",  load_busy, 0);
    check("rl_done",  load_done, 0);
    check("rl_err",   load_err, 0);
    check("rl_ready", ld_ready, 0);
    check("rl_we",    mem_we, 0);
    check("rl_wdata", mem_wdata, 0);
    check("rl_addr0", mem_addr, 0);
    check("rl_fvalid", fetch_valid, 0);
    check("rl_fstall", fetch_stall, 0);
    next_cycle; rst_n = 1'b1; sample;
    check("rl_post_done", load_done, 0);
    check("rl_post_err",  load_err, 0);
    check("rl_post_busy", load_busy, 0);
    check("rl_ram901", ram[901], 32'h5000_0000);
    check("rl_ram920", ram[920], 32'h5000_0013);
    check("rl_ram921", ram[921], 32'hC0DE_0399);

    // Full partition at the top of the process area; stray load_start mid-load
    next_cycle; load_start = 1'b1; load_pid = 4'd10; load_len = 12'd100; sample;
    for (int k = 0; k < 100; k++) begin
      next_cycle; load_start = (k == 50); load_pid = 4'd2; load_len = 12'd5;
      ld_valid = 1'b1; ld_data = 32'h6000_0000 + 32'(k); sample;
      check("bd_addr", mem_addr, 32'(901 + k));
      check("bd_busy", load_busy, 1);
      check("bd_err",  load_err, 0);
    end
    next_cycle; load_start = 1'b0; ld_valid = 1'b0; sample;
    check("bd_done", load_done, 1);
    next_cycle; sample;
    check("bd_done_pulse", load_done, 0);
    check("bd_err_after", load_err, 0);
    check("bd_ram901",  ram[901],  32'h6000_0000);
    check("bd_ram1000", ram[1000], 32'h6000_0063);
    check("bd_ram1001", ram[1001], 32'hC0DE_03E9);
    check("bd_ram1024", ram[1024], 32'hC0DE_0400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
